// File: rtl/hangman_pkg.sv
// Shared types and helpers for the hangman scheduler slice.
package hangman_pkg;

  typedef enum logic [2:0] {
    LOAD,
    ARM,
    PRIME,
    WAIT,
    BUSY,
    DONE
  } sched_state_t;

  localparam logic [7:0]  ASCII_A  = 8'h41;
  localparam logic [7:0]  ASCII_Z  = 8'h5A;
  localparam int unsigned WORD_LEN = 5;

  // Folds lower case to upper case; bit 8 flags an 'A'-'Z' letter.
  function automatic logic [8:0] to_upper_valid(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    return {(u >= ASCII_A && u <= ASCII_Z), u};
  endfunction

endpackage

// File: rtl/guess_fifo.sv
// Show-ahead guess FIFO with synchronous flush; push and pop may coincide.
module guess_fifo #(
  parameter int unsigned GUESS_DEPTH = 4,
  parameter int unsigned WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(GUESS_DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [GUESS_DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(GUESS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/guess_scheduler.sv
// Sequences the hangman core: word load, filtered guess queueing, issue handshake.
module guess_scheduler
  import hangman_pkg::*;
#(
  parameter int unsigned GUESS_DEPTH  = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  input  logic [7:0]  host_char,
  input  logic        host_enter,
  input  logic        guess_valid,
  input  logic [7:0]  guess_char,
  output logic        guess_ready,
  input  logic        new_game,
  input  logic        game_rdy,
  input  logic        red_busy,
  input  logic        red,
  input  logic        green,
  output logic [39:0] setWord,
  output logic        toggle_state,
  output logic [7:0]  guess,
  output logic        gameEnd,
  output logic        dup_guess,
  output logic        bad_char,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t   state_q, state_d;
  logic [39:0]    set_word_q, set_word_d;
  logic [2:0]     count_q, count_d;
  logic [25:0]    mask_q, mask_d;
  logic [7:0]     guess_q, guess_d;
  logic           pending_q, pending_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           seen_q, seen_d;
  logic           toggle_q, toggle_d;
  logic           game_end_q, game_end_d;
  logic           dup_q, dup_d;
  logic           bad_q, bad_d;
  logic           timeout_q, timeout_d;

  logic           push, pop, flush, full, empty;
  logic [7:0]     head;
  logic [8:0]     host_cv, guess_cv;
  logic [4:0]     g_idx;
  logic           accepting;

  guess_fifo #(.GUESS_DEPTH(GUESS_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (guess_cv[7:0]),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign host_cv   = to_upper_valid(host_char);
  assign guess_cv  = to_upper_valid(guess_char);
  assign g_idx     = 5'(guess_cv[7:0] - ASCII_A);
  assign accepting = state_q inside {ARM, PRIME, WAIT, BUSY};

  always_comb begin
    state_d    = state_q;
    set_word_d = set_word_q;
    count_d    = count_q;
    mask_d     = mask_q;
    guess_d    = guess_q;
    pending_d  = pending_q | new_game;
    timer_d    = timer_q;
    seen_d     = seen_q;
    toggle_d   = 1'b0;
    game_end_d = 1'b0;
    dup_d      = 1'b0;
    bad_d      = 1'b0;
    timeout_d  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    // Restart is only taken while the core is not mid-evaluation; any guess this cycle is discarded.
    if (pending_d && (state_q inside {LOAD, ARM, WAIT, DONE})) begin
      game_end_d = 1'b1;
      pending_d  = 1'b0;
      set_word_d = '0;
      guess_d    = '0;
      count_d    = '0;
      mask_d     = '0;
      flush      = 1'b1;
      state_d    = LOAD;
    end else begin
      if (accepting && guess_valid) begin
        if (!guess_cv[8]) begin
          bad_d = 1'b1;
        end else if (mask_q[g_idx]) begin
          dup_d = 1'b1;
        end else if (!full) begin
          push          = 1'b1;
          mask_d[g_idx] = 1'b1;
        end
      end

      unique case (state_q)
        LOAD: begin
          if (host_valid) begin
            if (!host_cv[8]) begin
              bad_d = 1'b1;
            end else if (count_q < 3'(WORD_LEN)) begin
              set_word_d = {set_word_q[31:0], host_cv[7:0]};
              count_d    = count_q + 3'd1;
            end
          end
          if (host_enter && count_q == 3'(WORD_LEN)) state_d = ARM;
        end
        ARM: begin
          if (!empty && game_rdy) begin
            pop     = 1'b1;
            guess_d = head;
            state_d = PRIME;
          end
        end
        PRIME: begin
          toggle_d = 1'b1;
          timer_d  = '0;
          seen_d   = 1'b0;
          state_d  = BUSY;
        end
        WAIT: begin
          if (red || green) begin
            state_d = DONE;
          end else if (!empty && game_rdy) begin
            pop     = 1'b1;
            guess_d = head;
            timer_d = '0;
            seen_d  = 1'b0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (seen_q) begin
            if (game_rdy) state_d = WAIT;
          end else if (red_busy) begin
            seen_d = 1'b1;
          end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = WAIT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        DONE: flush = 1'b1;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      set_word_q <= '0;
      count_q    <= '0;
      mask_q     <= '0;
      guess_q    <= '0;
      pending_q  <= 1'b0;
      timer_q    <= '0;
      seen_q     <= 1'b0;
      toggle_q   <= 1'b0;
      game_end_q <= 1'b0;
      dup_q      <= 1'b0;
      bad_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_word_q <= set_word_d;
      count_q    <= count_d;
      mask_q     <= mask_d;
      guess_q    <= guess_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      seen_q     <= seen_d;
      toggle_q   <= toggle_d;
      game_end_q <= game_end_d;
      dup_q      <= dup_d;
      bad_q      <= bad_d;
      timeout_q  <= timeout_d;
    end
  end

  assign guess_ready  = accepting && !full;
  assign setWord      = set_word_q;
  assign toggle_state = toggle_q;
  assign guess        = guess_q;
  assign gameEnd      = game_end_q;
  assign dup_guess    = dup_q;
  assign bad_char     = bad_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_guess_scheduler.sv
// Directed self-checking bench for guess_scheduler (GUESS_DEPTH=4, BUSY_TIMEOUT=16).
module tb_guess_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid, host_enter, guess_valid;
  logic [7:0]  host_char, guess_char;
  logic        guess_ready;
  logic        new_game, game_rdy, red_busy, red, green;
  logic [39:0] setWord;
  logic        toggle_state, gameEnd, dup_guess, bad_char, timeout_err;
  logic [7:0]  guess;

  int checks = 0;
  int errors = 0;

  guess_scheduler #(.GUESS_DEPTH(4), .BUSY_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_valid   (host_valid),
    .host_char    (host_char),
    .host_enter   (host_enter),
    .guess_valid  (guess_valid),
    .guess_char   (guess_char),
    .guess_ready  (guess_ready),
    .new_game     (new_game),
    .game_rdy     (game_rdy),
    .red_busy     (red_busy),
    .red          (red),
    .green        (green),
    .setWord      (setWord),
    .toggle_state (toggle_state),
    .guess        (guess),
    .gameEnd      (gameEnd),
    .dup_guess    (dup_guess),
    .bad_char     (bad_char),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_key(input logic [7:0] c);
    host_valid = 1'b1;
    host_char  = c;
    step();
    host_valid = 1'b0;
  endtask

  task automatic player_key(input logic [7:0] c);
    guess_valid = 1'b1;
    guess_char  = c;
    step();
    guess_valid = 1'b0;
  endtask

  // Completes a BUSY phase: core goes busy, then reports ready again.
  task automatic finish_busy();
    game_rdy = 1'b0;
    red_busy = 1'b1;
    step();
    red_busy = 1'b0;
    game_rdy = 1'b1;
    step();
    game_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] drain [4];
    drain = '{8'h42, 8'h43, 8'h44, 8'h45};

    rst = 1'b1; host_valid = 0; host_char = 0; host_enter = 0;
    guess_valid = 0; guess_char = 0; new_game = 0; game_rdy = 0;
    red_busy = 0; red = 0; green = 0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_setword", setWord, 40'h0);
    chk("rst_guess", guess, 8'h00);
    chk("rst_ready", guess_ready, 1'b0);
    chk("rst_toggle", toggle_state, 1'b0);
    chk("rst_gameend", gameEnd, 1'b0);

    // 1: load "hello", extra letter ignored, arm, first guess
    host_key(8'h68); host_key(8'h65); host_key(8'h6C); host_key(8'h6C); host_key(8'h6F);
    chk("load_word", setWord, 40'h48454C4C4F);
    host_key(8'h78);
    chk("load_sixth_ignored", setWord, 40'h48454C4C4F);
    chk("load_ready_low", guess_ready, 1'b0);
    host_enter = 1'b1; step(); host_enter = 1'b0;
    chk("arm_ready", guess_ready, 1'b1);
    player_key(8'h48);
    step();
    chk("arm_hold_no_rdy", guess, 8'h00);
    game_rdy = 1'b1; step(); game_rdy = 1'b0;
    chk("prime_guess", guess, 8'h48);
    chk("prime_no_toggle", toggle_state, 1'b0);
    step();
    chk("toggle_pulse", toggle_state, 1'b1);
    step();
    chk("toggle_one_cycle", toggle_state, 1'b0);
    finish_busy();

    // 2: A, a (dup), Z issued in order
    player_key(8'h41);
    chk("dup_first_a", dup_guess, 1'b0);
    player_key(8'h61);
    chk("dup_lower_a", dup_guess, 1'b1);
    player_key(8'h5A);
    chk("dup_clear", dup_guess, 1'b0);
    game_rdy = 1'b1; step();
    chk("issue_a", guess, 8'h41);
    game_rdy = 1'b0; red_busy = 1'b1; step(); red_busy = 1'b0; step();
    chk("hold_while_busy", guess, 8'h41);
    game_rdy = 1'b1; step(); step();
    chk("issue_z", guess, 8'h5A);
    finish_busy();

    // 3: bad characters
    player_key(8'h33);
    chk("bad_digit", bad_char, 1'b1);
    player_key(8'h20);
    chk("bad_space", bad_char, 1'b1);
    step();
    chk("bad_clear", bad_char, 1'b0);

    // 4: fill to depth, fifth dropped, drain in order
    player_key(8'h42); player_key(8'h43); player_key(8'h44);
    chk("ready_three", guess_ready, 1'b1);
    player_key(8'h45);
    chk("ready_full", guess_ready, 1'b0);
    player_key(8'h46);
    chk("full_drop_silent", dup_guess, 1'b0);
    for (int i = 0; i < 4; i++) begin
      game_rdy = 1'b1; step();
      chk("drain_order", guess, drain[i]);
      chk("drain_ready", guess_ready, 1'b1);
      finish_busy();
    end
    player_key(8'h46);
    chk("dropped_not_marked", dup_guess, 1'b0);

    // 5: busy timeout
    game_rdy = 1'b1; step(); game_rdy = 1'b0;
    chk("issue_f", guess, 8'h46);
    for (int i = 1; i < 16; i++) step();
    chk("timeout_not_yet", timeout_err, 1'b0);
    step();
    chk("timeout_pulse", timeout_err, 1'b1);
    step();
    chk("timeout_one_cycle", timeout_err, 1'b0);
    player_key(8'h47);
    game_rdy = 1'b1; step();
    chk("wait_after_timeout", guess, 8'h47);
    finish_busy();

    // 6: green -> DONE flush, new_game restart
    player_key(8'h49);
    green = 1'b1; step(); green = 1'b0;
    step();
    chk("done_ready_low", guess_ready, 1'b0);
    chk("done_guess_kept", guess, 8'h47);
    new_game = 1'b1; step(); new_game = 1'b0;
    chk("ng_gameend", gameEnd, 1'b1);
    chk("ng_setword", setWord, 40'h0);
    chk("ng_guess", guess, 8'h00);
    chk("ng_ready", guess_ready, 1'b0);
    step();
    chk("ng_gameend_one", gameEnd, 1'b0);

    // 5th letter with enter in the same cycle: enter not honoured yet
    host_key(8'h77); host_key(8'h6F); host_key(8'h72); host_key(8'h6C);
    host_enter = 1'b1; host_key(8'h64); host_enter = 1'b0;
    step();
    chk("enter_with_fifth", guess_ready, 1'b0);
    chk("word2", setWord, 40'h574F524C44);
    host_enter = 1'b1; step(); host_enter = 1'b0;
    chk("arm2_ready", guess_ready, 1'b1);
    game_rdy = 1'b1; step();
    chk("fifo_was_flushed", guess, 8'h00);
    player_key(8'h41);
    chk("mask_cleared", dup_guess, 1'b0);
    step();
    chk("issue_a2", guess, 8'h41);
    game_rdy = 1'b0;
    step();
    new_game = 1'b1; step(); new_game = 1'b0;
    chk("ng_deferred_busy", gameEnd, 1'b0);
    red_busy = 1'b1; step(); red_busy = 1'b0;
    chk("ng_deferred_busy2", gameEnd, 1'b0);
    game_rdy = 1'b1; step(); game_rdy = 1'b0;
    chk("ng_enter_wait", gameEnd, 1'b0);
    step();
    chk("ng_serviced", gameEnd, 1'b1);
    chk("ng_serviced_guess", guess, 8'h00);
    step();
    chk("ng_serviced_one", gameEnd, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_scheduler.md
Name: guess_scheduler

Overview:
- Sequences the hangman game core: assembles the host's 5-letter word into setWord and arms the game.
- Queues player guesses and presents each to the core only when the core is ready, then waits for the core to finish evaluating it.
- Filters invalid and repeated letters. The core only evaluates a guess when it differs from the previous one, so repeated letters never reach it.
- Sits between the UART/keypad receivers (host and player) and the game core.

Parameters:
- GUESS_DEPTH, 4, guess FIFO entries (power of two, ≥2).
- BUSY_TIMEOUT, 16, cycles to wait for red_busy after a guess is issued.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- host_valid  in  1  host character strobe.
- host_char  in  8  host ASCII character.
- host_enter  in  1  host confirms the word.
- guess_valid  in  1  player character strobe.
- guess_char  in  8  player ASCII character.
- guess_ready  out  1  FIFO can accept a guess.
- new_game  in  1  request to restart.
- game_rdy  in  1  from core.
- red_busy  in  1  from core.
- red  in  1  from core.
- green  in  1  from core.
- setWord  out  40  word to core; first letter in [39:32].
- toggle_state  out  1  one-cycle start pulse to core.
- guess  out  8  current guess to core; 0 means none.
- gameEnd  out  1  one-cycle restart pulse to core.
- dup_guess  out  1  one-cycle pulse: letter already guessed, dropped.
- bad_char  out  1  one-cycle pulse: non-letter dropped.
- timeout_err  out  1  one-cycle pulse: core never went busy.

Behaviour:
- Reset values: all outputs 0, setWord=0, guess=0, FIFO empty, used-mask (26 bits) clear, letter count 0, state LOAD. Reset mid-operation aborts immediately; gameEnd is not pulsed.
- Character rule: 'a'-'z' are folded to 'A'-'Z'. Only 0x41-0x5A are valid. Anything else raises bad_char and is dropped.
- LOAD state:
  - Each valid host_char with count<5 does setWord <= {setWord[31:0], char} and count++.
  - Characters arriving at count==5 are ignored.
  - host_enter with count==5 → ARM. host_enter with count<5 is ignored.
  - guess_ready=0 in LOAD.
- Guess acceptance (ARM through WAIT):
  - guess_ready = ~full.
  - A valid, unused letter is pushed into the FIFO and its mask bit is set in the same cycle.
  - A used letter raises dup_guess and is not pushed.
  - guess_valid while full is dropped silently.
- ARM state:
  - The core only starts with a nonzero letter sampled from guess, so the first guess must already be on guess before toggle_state.
  - Wait for FIFO non-empty and game_rdy=1. Then pop the entry onto guess → PRIME.
- PRIME state: one cycle with guess held stable; toggle_state=1 → BUSY.
- WAIT state (core idle):
  - red|green=1 → DONE.
  - Else FIFO non-empty and game_rdy=1 → pop onto guess → BUSY. guess changes only on this pop.
- BUSY state:
  - Wait for red_busy=1, then wait for game_rdy=1 → WAIT.
  - If red_busy is not seen within BUSY_TIMEOUT cycles of entry: pulse timeout_err → WAIT. The guess is lost; its mask bit stays set.
- DONE state: flush the FIFO; guess_ready=0. guess keeps the last value.
- new_game handling:
  - new_game is latched as pending in any state.
  - It is serviced in LOAD, ARM, WAIT or DONE, never in PRIME or BUSY.
  - Servicing: gameEnd=1 for one cycle; clear setWord, guess, count, mask and FIFO → LOAD.
  - In LOAD or ARM the core is in SET, so gameEnd is harmless.
- Simultaneous events:
  - Push and pop in the same cycle are both allowed, including when full.
  - new_game in the same cycle as a guess: the guess is discarded.
  - host_enter in the same cycle as the 5th letter: the letter is accepted first; the enter is honoured next cycle only if still asserted.
- FIFO pointers wrap modulo GUESS_DEPTH. The count register is log2(GUESS_DEPTH)+1 bits.

Decomposition:
- Shared package hangman_pkg:
  - sched_state_t enum {LOAD, ARM, PRIME, WAIT, BUSY, DONE}.
  - ASCII_A=8'h41, ASCII_Z=8'h5A, WORD_LEN=5.
  - Function to_upper_valid returning {valid, letter}.
- One sub-module: guess_fifo (parameterised GUESS_DEPTH×8, push/pop/full/empty/flush).

Test Plan:
1. Host "h","e","l","l","o", then host_enter; player "H" → setWord=0x48454C4C4F; guess=0x48 one cycle before the toggle_state pulse; then BUSY→WAIT.
2. Player "A","a","Z" → "A" is queued, the second "a" raises dup_guess, "Z" is queued; guesses are issued in order 0x41, 0x5A, each only after game_rdy returns.
3. Player "3" and 0x20 → bad_char pulses twice; FIFO unchanged.
4. Hold game_rdy=0 and push 5 letters with GUESS_DEPTH=4 → guess_ready drops after 4; the 5th is dropped; after release the 4 letters drain in order.
5. Never assert red_busy after an issue → timeout_err pulses 16 cycles after entering BUSY; state returns to WAIT.
6. green=1 in WAIT → DONE with FIFO flushed. Then new_game → gameEnd for exactly 1 cycle, setWord=0, guess=0, state LOAD. new_game asserted during BUSY is deferred until WAIT.
